// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer.
//   MD_* op codes   3-bit muldiv op selector driven by decode
//   md_state_e      sequencer FSM states
//   MD_DIV_ITER     divider iteration count (operand width)
//   md_is_div/mul   op-class helpers
package muldiv_pkg;

    localparam logic [2:0] MD_DIV   = 3'd0;
    localparam logic [2:0] MD_DIVU  = 3'd1;
    localparam logic [2:0] MD_MULT  = 3'd2;
    localparam logic [2:0] MD_MULTU = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MD_DIV_ITER = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIV_RUN  = 2'd1,
        ST_MUL_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } md_state_e;

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/div_iter_core.sv
// Unsigned restoring shift-subtract divider, one quotient bit per step.
// Operands arrive as magnitudes; sign handling is done by the caller.
//   clk, rst    core clock, synchronous active-high reset (counter only)
//   start       load a_abs/b_abs, clear remainder and iteration counter
//   step        perform one iteration
//   a_abs       dividend magnitude (held in the quotient register until shifted out)
//   b_abs       divisor magnitude
//   quotient    quotient register (equals a_abs right after start)
//   remainder   partial / final remainder register
//   done        high during the step that produces the final quotient bit
// A zero divisor needs no special case: every trial subtract succeeds, giving
// quotient all ones and remainder equal to the dividend.
module div_iter_core #(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step,
    input  logic [31:0] a_abs,
    input  logic [31:0] b_abs,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    localparam logic [5:0] CNT_LAST = 6'(DIV_ITER - 1);

    logic [5:0]  cnt_p0;
    logic [31:0] b_p0;
    logic [31:0] quo_p0;
    logic [31:0] rem_p0;

    logic [32:0] shifted;
    logic        take;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;

    always_comb begin
        shifted = {rem_p0, quo_p0[31]};
        take    = shifted >= {1'b0, b_p0};
        // When the subtract is taken the true difference is below 2^32,
        // so the low 32 bits are exact.
        rem_nxt = take ? (shifted[31:0] - b_p0) : shifted[31:0];
        quo_nxt = {quo_p0[30:0], take};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0 <= '0;
        end else if (start) begin
            cnt_p0 <= '0;
        end else if (step) begin
            cnt_p0 <= cnt_p0 + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            b_p0   <= b_abs;
            quo_p0 <= a_abs;
            rem_p0 <= '0;
        end else if (step) begin
            quo_p0 <= quo_nxt;
            rem_p0 <= rem_nxt;
        end
    end

    assign done      = step && (cnt_p0 == CNT_LAST);
    assign quotient  = quo_p0;
    assign remainder = rem_p0;

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer and owner of the HI/LO registers.
// Runs div/divu on div_iter_core, times an external pipelined multiplier for
// mult/multu, and writes mthi/mtlo directly. stallreq holds the pipeline until
// the result lands in HI/LO; md_done pulses on the edge that writes HI/LO.
//   clk, rst     core clock, synchronous active-high reset
//   op_valid/op  muldiv-class instruction in EX (held while stalled)
//   cancel       flush: abort in-flight op, HI/LO untouched
//   src1, src2   rs / rt values
//   mul_ina/inb/mul_signed  operands to external multiplier
//   mul_result   product, valid MUL_LAT cycles after operands are presented
//   stallreq     stall request to IF..EX (combinational)
//   md_done      HI/LO written this edge
//   hi, lo       HI/LO registers
// Build option: define MULDIV_DIV0_FAST_EN to finish a divide by zero after a
// single stall cycle instead of running all DIV_ITER iterations.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = MD_DIV_ITER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic        cancel,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    output logic        mul_signed,
    input  logic [63:0] mul_result,
    output logic        stallreq,
    output logic        md_done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [7:0] MUL_CNT_LAST = 8'(MUL_LAT - 2);

    function automatic logic [31:0] magnitude(input logic signed [31:0] v, input logic sgn);
        return (sgn && v < 0) ? 32'(-v) : 32'(v);
    endfunction

    function automatic logic [31:0] apply_sign(input logic [31:0] mag, input logic neg);
        logic signed [31:0] m;
        m = mag;
        return neg ? 32'(-m) : 32'(m);
    endfunction

    md_state_e   state_p0;
    md_state_e   state_nxt;
    logic [7:0]  mcnt_p0;

    logic [31:0] mul_a_p0;
    logic [31:0] mul_b_p0;
    logic        mul_sgn_p0;
    logic        neg_q_p0;
    logic        neg_r_p0;
    logic        is_div_p0;

    logic        act;
    logic        is_div;
    logic        is_mul;
    logic        is_mthi;
    logic        is_mtlo;
    logic        div_sgn;
    logic        div_fast;

    logic        div_start;
    logic        div_step;
    logic        mul_new;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic        div_last;
    logic [31:0] quo_wb;
    logic [31:0] rem_wb;

    assign act     = !rst && !cancel;
    assign is_div  = op_valid && md_is_div(op);
    assign is_mul  = op_valid && md_is_mul(op);
    assign is_mthi = op_valid && (op == MD_MTHI);
    assign is_mtlo = op_valid && (op == MD_MTLO);
    assign div_sgn = (op == MD_DIV);

`ifdef MULDIV_DIV0_FAST_EN
    logic div0_p0;

    assign div_fast = (src2 == '0);
    // On the fast path the core only saw start, so its quotient register
    // still holds the dividend magnitude: that is the remainder to report.
    assign quo_wb   = div0_p0 ? '1 : div_quo;
    assign rem_wb   = div0_p0 ? div_quo : div_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            div0_p0 <= 1'b0;
        end else if (div_start) begin
            div0_p0 <= div_fast;
        end
    end
`else
    assign div_fast = 1'b0;
    assign quo_wb   = div_quo;
    assign rem_wb   = div_rem;
`endif

    div_iter_core #(
        .DIV_ITER (DIV_ITER)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .step      (div_step),
        .a_abs     (magnitude(src1, div_sgn)),
        .b_abs     (magnitude(src2, div_sgn)),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_last)
    );

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= ST_IDLE;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcnt_p0 <= '0;
        end else if (state_p0 == ST_MUL_WAIT && !cancel) begin
            mcnt_p0 <= mcnt_p0 + 8'd1;
        end else begin
            mcnt_p0 <= '0;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_nxt = state_p0;
        if (cancel) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_p0)
                ST_IDLE: begin
                    if (is_div) begin
                        state_nxt = div_fast ? ST_DONE : ST_DIV_RUN;
                    end else if (is_mul) begin
                        state_nxt = (MUL_LAT == 1) ? ST_DONE : ST_MUL_WAIT;
                    end
                end
                ST_DIV_RUN:  if (div_last) state_nxt = ST_DONE;
                ST_MUL_WAIT: if (mcnt_p0 == MUL_CNT_LAST) state_nxt = ST_DONE;
                ST_DONE:     state_nxt = ST_IDLE;
                default:     state_nxt = ST_IDLE;
            endcase
        end
    end

    // ---- output logic ----
    always_comb begin
        stallreq  = 1'b0;
        md_done   = 1'b0;
        div_start = 1'b0;
        div_step  = 1'b0;
        mul_new   = 1'b0;
        if (act) begin
            case (state_p0)
                ST_IDLE: begin
                    if (is_div) begin
                        stallreq  = 1'b1;
                        div_start = 1'b1;
                    end else if (is_mul) begin
                        stallreq  = 1'b1;
                        mul_new   = 1'b1;
                    end else if (is_mthi || is_mtlo) begin
                        md_done   = 1'b1;
                    end
                end
                ST_DIV_RUN: begin
                    stallreq = 1'b1;
                    div_step = 1'b1;
                end
                ST_MUL_WAIT: stallreq = 1'b1;
                ST_DONE:     md_done  = 1'b1;
                default:     stallreq = 1'b0;
            endcase
        end
    end

    // The multiplier sees the live operands on the issue cycle and the
    // latched copies afterwards, so later changes on src1/src2 are ignored.
    assign mul_ina    = mul_new ? src1 : mul_a_p0;
    assign mul_inb    = mul_new ? src2 : mul_b_p0;
    assign mul_signed = mul_new ? (op == MD_MULT) : mul_sgn_p0;

    // ---- operand latch and HI/LO writeback ----
    always_ff @(posedge clk) begin
        if (rst) begin
            hi         <= '0;
            lo         <= '0;
            mul_a_p0   <= '0;
            mul_b_p0   <= '0;
            mul_sgn_p0 <= 1'b0;
            neg_q_p0   <= 1'b0;
            neg_r_p0   <= 1'b0;
            is_div_p0  <= 1'b0;
        end else begin
            if (mul_new) begin
                mul_a_p0   <= src1;
                mul_b_p0   <= src2;
                mul_sgn_p0 <= (op == MD_MULT);
                is_div_p0  <= 1'b0;
            end
            if (div_start) begin
                neg_q_p0  <= div_sgn && (src1[31] ^ src2[31]);
                neg_r_p0  <= div_sgn && src1[31];
                is_div_p0 <= 1'b1;
            end
            if (act && state_p0 == ST_IDLE && is_mthi) hi <= src1;
            if (act && state_p0 == ST_IDLE && is_mtlo) lo <= src1;
            if (act && state_p0 == ST_DONE) begin
                if (is_div_p0) begin
                    lo <= apply_sign(quo_wb, neg_q_p0);
                    hi <= apply_sign(rem_wb, neg_r_p0);
                end else begin
                    lo <= mul_result[31:0];
                    hi <= mul_result[63:32];
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int MUL_LAT  = 2;
    localparam int DIV_ITER = 32;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic        cancel;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] mul_ina;
    logic [31:0] mul_inb;
    logic        mul_signed;
    logic [63:0] mul_result;
    logic        stallreq;
    logic        md_done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    muldiv_ctrl #(
        .MUL_LAT  (MUL_LAT),
        .DIV_ITER (DIV_ITER)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op         (op),
        .cancel     (cancel),
        .src1       (src1),
        .src2       (src2),
        .mul_ina    (mul_ina),
        .mul_inb    (mul_inb),
        .mul_signed (mul_signed),
        .mul_result (mul_result),
        .stallreq   (stallreq),
        .md_done    (md_done),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External pipelined multiplier: product of the operands seen MUL_LAT edges ago.
    logic [63:0] mpipe [MUL_LAT];
    logic [63:0] prod_now;
    always_comb begin
        if (mul_signed) prod_now = 64'(longint'($signed(mul_ina)) * longint'($signed(mul_inb)));
        else            prod_now = {32'b0, mul_ina} * {32'b0, mul_inb};
    end
    always @(posedge clk) begin
        mpipe[0] <= prod_now;
        for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_result = mpipe[MUL_LAT-1];

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    // Reference {hi,lo} after an op, from the arithmetic rules of the instruction set.
    function automatic logic [63:0] ref_hilo(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint ma, mb, uq, ur, q, r;
        bit sgn, na, nb;
        logic [63:0] x, y;
        case (o)
            MD_DIV, MD_DIVU: begin
                sgn = (o == MD_DIV);
                na  = sgn && a[31];
                nb  = sgn && b[31];
                ma  = na ? -longint'($signed(a)) : longint'(a);
                mb  = nb ? -longint'($signed(b)) : longint'(b);
                if (mb == 0) begin
                    uq = 64'hFFFF_FFFF;
                    ur = ma;
                end else begin
                    uq = ma / mb;
                    ur = ma % mb;
                end
                q = (na != nb) ? -uq : uq;
                r = na ? -ur : ur;
                return {r[31:0], q[31:0]};
            end
            MD_MULT:  return 64'(longint'($signed(a)) * longint'($signed(b)));
            MD_MULTU: begin
                x = {32'b0, a};
                y = {32'b0, b};
                return x * y;
            end
            MD_MTHI:  return {a, m_lo};
            default:  return {m_hi, a};
        endcase
    endfunction

    function automatic int ref_stall(input logic [2:0] o, input logic [31:0] b);
        if (md_is_div(o)) begin
`ifdef MULDIV_DIV0_FAST_EN
            if (b == 0) return 1;
`endif
            return 1 + DIV_ITER;
        end
        if (md_is_mul(o)) return MUL_LAT;
        return 0;
    endfunction

    // Issue one op, count stall cycles, scramble operands while stalled, check writeback.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        int stalls = 0;
        int pulses = 0;
        bit tout = 0;
        logic [63:0] exp_hl;
        int exp_st;
        exp_hl = ref_hilo(o, a, b);
        exp_st = ref_stall(o, b);
        @(posedge clk); #1;
        op_valid = 1'b1; op = o; src1 = a; src2 = b;
        forever begin
            @(negedge clk);
            if (!stallreq) break;
            stalls++;
            if (md_done) pulses++;
            if (md_is_mul(o) && stalls == MUL_LAT) begin
                check($sformatf("%s_mulops", tag), {mul_ina, mul_inb}, {a, b});
                check($sformatf("%s_mulsgn", tag), 64'(mul_signed), 64'(o == MD_MULT));
            end
            if (stalls > 100) begin
                tout = 1;
                break;
            end
            @(posedge clk); #1;
            src1 = $urandom; src2 = $urandom;
        end
        check($sformatf("%s_timeout", tag), 64'(tout), 64'd0);
        check($sformatf("%s_stall", tag), 64'(stalls), 64'(exp_st));
        check($sformatf("%s_early_done", tag), 64'(pulses), 64'd0);
        check($sformatf("%s_done", tag), 64'(md_done), 64'd1);
        @(posedge clk); #1;
        op_valid = 1'b0;
        m_hi = exp_hl[63:32];
        m_lo = exp_hl[31:0];
        @(negedge clk);
        check($sformatf("%s_hilo", tag), {hi, lo}, {m_hi, m_lo});
        check($sformatf("%s_idle", tag), {62'b0, stallreq, md_done}, 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; op_valid = 1'b0; op = MD_DIVU; cancel = 1'b0; src1 = '0; src2 = '0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_ctl", {61'b0, stallreq, md_done, mul_signed}, 64'd0);
        check("reset_mulops", {mul_ina, mul_inb}, 64'd0);

        run_op(MD_DIVU,  32'd100,        32'd7,          "divu_100_7");
        run_op(MD_DIV,   32'hFFFF_FFF9,  32'd2,          "div_m7_2");
        run_op(MD_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  "div_ovf");
        run_op(MD_MULTU, 32'hFFFF_FFFF,  32'd2,          "multu_max_2");
        run_op(MD_MULT,  32'hFFFF_FFFD,  32'd4,          "mult_m3_4");
        run_op(MD_DIVU,  32'd5,          32'd0,          "divu_5_0");
        run_op(MD_DIV,   32'hFFFF_FFFB,  32'd0,          "div_m5_0");

        // mthi then mtlo on consecutive cycles
        @(posedge clk); #1;
        op_valid = 1'b1; op = MD_MTHI; src1 = 32'h1234;
        @(negedge clk);
        check("mthi_ctl", {62'b0, stallreq, md_done}, 64'd1);
        @(posedge clk); #1;
        op = MD_MTLO; src1 = 32'h5678;
        @(negedge clk);
        check("mtlo_ctl", {62'b0, stallreq, md_done}, 64'd1);
        check("mthi_hi", 64'(hi), 64'h1234);
        @(posedge clk); #1;
        op_valid = 1'b0;
        m_hi = 32'h1234; m_lo = 32'h5678;
        @(negedge clk);
        check("mt_hilo", {hi, lo}, {m_hi, m_lo});
        check("mt_idle", 64'(md_done), 64'd0);

        for (int i = 0; i < 20; i++) begin
            logic [2:0]  o;
            logic [31:0] a, b;
            o = 3'($urandom_range(0, 5));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 2) == 0) b = $urandom_range(0, 20);
            if ($urandom_range(0, 5) == 0) b = '0;
            run_op(o, a, b, $sformatf("rnd%0d", i));
        end

        // cancel during the tenth divide iteration, op_valid still high
        @(posedge clk); #1;
        op_valid = 1'b1; op = MD_DIV; src1 = 32'd1000; src2 = 32'd3;
        repeat (10) @(negedge clk);
        check("cx_stall_before", 64'(stallreq), 64'd1);
        @(posedge clk); #1;
        cancel = 1'b1;
        @(negedge clk);
        check("cx_ctl_during", {62'b0, stallreq, md_done}, 64'd0);
        @(posedge clk); #1;
        cancel = 1'b0; op_valid = 1'b0;
        @(negedge clk);
        check("cx_stall_after", 64'(stallreq), 64'd0);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (md_done || stallreq) n++;
        end
        check("cx_no_write", 64'(n), 64'd0);
        check("cx_hilo", {hi, lo}, {m_hi, m_lo});

        // cancel beats a same-cycle mthi
        @(posedge clk); #1;
        op_valid = 1'b1; op = MD_MTHI; src1 = 32'hDEAD_BEEF; cancel = 1'b1;
        @(negedge clk);
        check("cx_mthi_done", 64'(md_done), 64'd0);
        @(posedge clk); #1;
        op_valid = 1'b0; cancel = 1'b0;
        @(negedge clk);
        check("cx_mthi_hilo", {hi, lo}, {m_hi, m_lo});

        // reset twenty cycles into a divide
        run_op(MD_MTHI, 32'hABCD, 32'd0, "pre_rst");
        @(posedge clk); #1;
        op_valid = 1'b1; op = MD_DIVU; src1 = 32'd77; src2 = 32'd5;
        repeat (20) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_ctl_during", {62'b0, stallreq, md_done}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; op_valid = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_ctl_after", {62'b0, stallreq, md_done}, 64'd0);
        check("rst_mulops", {mul_ina, mul_inb}, 64'd0);

        run_op(MD_MULTU, 32'd3, 32'd5, "post_rst_multu");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
